// File: rtl/act_pkg.sv
// act_pkg: shared definitions for the act_requant requantisation stage.
//   - act_state_e : frame sequencer states
//   - PIPE_LAT    : datapath latency in cycles (S1 bias add, S2 shift, S3 relu/saturate)
//   - sat_max/min : signed saturation limits for a given output width
package act_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } act_state_e;

  localparam int PIPE_LAT = 3;

  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction

endpackage

// File: rtl/act_lane.sv
// act_lane: one lane of the requantisation datapath, three register stages.
//   S1: r_sum = sext(acc) + sext(bias)          (AW+1 bits, cannot overflow)
//   S2: r_sh  = r_sum >>> shift                 (floor)
//       with ACT_ROUND_EN defined, 1<<(shift-1) is added first (round half up)
//   S3: optional ReLU, then saturate to DW-bit signed
// Each stage register only loads when its enable is high, so the output holds
// its last value between beats.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_acc  [AW]           signed accumulator
//   i_bias [BW]           signed bias
//   i_shift[5]            arithmetic right-shift amount
//   i_relu                clamp negatives to zero
//   i_en1/i_en2/i_en3     load enables for S1/S2/S3
//   o_data [DW]           saturated activation
// Macro: ACT_ROUND_EN selects round-half-up in S2.
module act_lane
  import act_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 24,
  parameter int BW = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic signed [AW-1:0] i_acc,
  input  logic signed [BW-1:0] i_bias,
  input  logic [4:0]           i_shift,
  input  logic                 i_relu,
  input  logic                 i_en1,
  input  logic                 i_en2,
  input  logic                 i_en3,
  output logic signed [DW-1:0] o_data
);

  localparam int SW = AW + 1;
`ifdef ACT_ROUND_EN
  localparam int HW = AW + 2;
`else
  localparam int HW = AW + 1;
`endif

  localparam logic signed [HW-1:0] SAT_HI = HW'(sat_max(DW));
  localparam logic signed [HW-1:0] SAT_LO = HW'(sat_min(DW));

  logic signed [SW-1:0] r_sum;
  logic signed [SW-1:0] w_sum;
  logic signed [HW-1:0] r_sh;
  logic signed [HW-1:0] w_sh;
  logic signed [DW-1:0] w_out;

  assign w_sum = $signed({i_acc[AW-1], i_acc}) + $signed({{(SW-BW){i_bias[BW-1]}}, i_bias});

`ifdef ACT_ROUND_EN
  logic        [HW-1:0] w_rnd;
  logic signed [HW-1:0] w_pre;

  // For shift >= SW any in-range sum rounds to 0. Capping the half-LSB at
  // 2^(SW-1) keeps the biased sum non-negative and inside HW bits, so the
  // shift still yields 0 without needing a wider adder.
  always_comb begin
    w_rnd = '0;
    if (i_shift >= 5'(SW))
      w_rnd = HW'(1) << (SW - 1);
    else
      w_rnd = (HW'(1) << i_shift) >> 1;
  end

  assign w_pre = $signed({r_sum[SW-1], r_sum}) + $signed(w_rnd);
  assign w_sh  = w_pre >>> i_shift;
`else
  assign w_sh  = r_sum >>> i_shift;
`endif

  always_comb begin
    w_out = r_sh[DW-1:0];
    if (i_relu && r_sh[HW-1])
      w_out = '0;
    else if (r_sh > SAT_HI)
      w_out = SAT_HI[DW-1:0];
    else if (r_sh < SAT_LO)
      w_out = SAT_LO[DW-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum  <= '0;
      r_sh   <= '0;
      o_data <= '0;
    end else begin
      if (i_en1) r_sum  <= w_sum;
      if (i_en2) r_sh   <= w_sh;
      if (i_en3) o_data <= w_out;
    end
  end

endmodule

// File: rtl/act_requant.sv
// act_requant: requantisation/activation stage feeding the max-pool stage.
// Per lane: bias add -> arithmetic right shift -> optional ReLU -> saturate.
// Frames are delimited by a programmed beat count; no backpressure.
//
// state    | meaning
// ST_IDLE  | waiting for cfg_load; beats dropped
// ST_RUN   | accepting beats, counting toward cfg_beats
// ST_DRAIN | last beat in flight; further beats dropped until it exits
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_data/in_valid     DN signed AW-bit accumulators and beat strobe
//   cfg_load             latches cfg_* (honoured in IDLE only)
//   cfg_bias/shift/relu  per-lane bias, shift amount, ReLU enable
//   cfg_beats            beats per frame (0 is rejected)
//   cfg_ctrl             ctrl word forwarded on s_ctrl for the frame
//   s_data/s_valid       DN signed DW-bit activations, 3 cycles after input
//   s_ctrl/s_last        latched ctrl, final-beat marker
//   done                 pulses with s_last
//   err                  sticky protocol error, cleared by an accepted cfg_load
// Macro: ACT_ROUND_EN enables round-half-up in the shift stage.
module act_requant
  import act_pkg::*;
#(
  parameter int DN = 7,
  parameter int DW = 8,
  parameter int AW = 24,
  parameter int BW = 16,
  parameter int CW = 9,
  parameter int NW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DN*AW-1:0]   in_data,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [DN*BW-1:0]   cfg_bias,
  input  logic [4:0]         cfg_shift,
  input  logic               cfg_relu,
  input  logic [NW-1:0]      cfg_beats,
  input  logic [CW-1:0]      cfg_ctrl,
  output logic [DN*DW-1:0]   s_data,
  output logic               s_valid,
  output logic [CW-1:0]      s_ctrl,
  output logic               s_last,
  output logic               done,
  output logic               err
);

  act_state_e          r_state;
  logic [NW-1:0]       r_cnt;
  logic [NW-1:0]       r_beats;
  logic [DN*BW-1:0]    r_bias;
  logic [4:0]          r_shift;
  logic                r_relu;
  logic [CW-1:0]       r_ctrl;
  logic                r_err;
  logic                r_done;
  logic [PIPE_LAT-1:0] r_vld;
  logic [PIPE_LAT-1:0] r_last;

  logic w_acc;
  logic w_cnt_end;
  logic w_load_ok;
  logic w_err_set;
  logic w_tail;

  assign w_acc     = in_valid && (r_state == ST_RUN);
  assign w_cnt_end = (r_cnt == r_beats - NW'(1));
  assign w_load_ok = cfg_load && (r_state == ST_IDLE) && (cfg_beats != '0);
  assign w_err_set = (cfg_load && !w_load_ok) || (in_valid && !w_acc);
  // Tagged beat moving into the output stage on this edge.
  assign w_tail    = r_vld[PIPE_LAT-2] & r_last[PIPE_LAT-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_beats <= '0;
      r_bias  <= '0;
      r_shift <= '0;
      r_relu  <= 1'b0;
      r_ctrl  <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_vld   <= '0;
      r_last  <= '0;
    end else begin
      r_vld  <= {r_vld[PIPE_LAT-2:0], w_acc};
      r_last <= {r_last[PIPE_LAT-2:0], w_acc & w_cnt_end};
      r_done <= w_tail;

      case (r_state)
        ST_IDLE: begin
          if (w_load_ok) begin
            r_beats <= cfg_beats;
            r_bias  <= cfg_bias;
            r_shift <= cfg_shift;
            r_relu  <= cfg_relu;
            r_ctrl  <= cfg_ctrl;
            r_cnt   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_acc) begin
            if (w_cnt_end)
              r_state <= ST_DRAIN;
            else
              r_cnt <= r_cnt + NW'(1);
          end
        end
        ST_DRAIN: begin
          if (w_tail)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      // A dropped beat in the load cycle must leave err set, so set wins.
      if (w_load_ok) r_err <= 1'b0;
      if (w_err_set) r_err <= 1'b1;
    end
  end

  assign s_valid = r_vld[PIPE_LAT-1];
  assign s_last  = r_last[PIPE_LAT-1];
  assign s_ctrl  = r_ctrl;
  assign done    = r_done;
  assign err     = r_err;

  for (genvar gi = 0; gi < DN; gi++) begin : g_lane
    act_lane #(
      .DW(DW),
      .AW(AW),
      .BW(BW)
    ) u_lane (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .i_acc  (in_data[gi*AW +: AW]),
      .i_bias (r_bias[gi*BW +: BW]),
      .i_shift(r_shift),
      .i_relu (r_relu),
      .i_en1  (w_acc),
      .i_en2  (r_vld[0]),
      .i_en3  (r_vld[1]),
      .o_data (s_data[gi*DW +: DW])
    );
  end

endmodule
